// File: rtl/sinc3_decimator.sv
// Third-order CIC (sinc3) decimator with a valid/ready output register.
// Optional sticky overrun flag when SINC3_DECIM_OVERRUN_EN is defined.
`timescale 1ns/1ps
module sinc3_decimator #(
  parameter int IN_WIDTH = 1,
  parameter int OSR = 32,
  localparam int OUT_WIDTH = 3*$clog2(OSR)+IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  in,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef SINC3_DECIM_OVERRUN_EN
  ,
  output logic                 overrun
`endif
);

  localparam int CW = $clog2(OSR);

  logic [OUT_WIDTH-1:0] x_s;
  logic [OUT_WIDTH-1:0] int1_r, int2_r, int3_r;
  logic [OUT_WIDTH-1:0] int1_s, int2_s, int3_s;
  logic [OUT_WIDTH-1:0] dly1_r, dly2_r, dly3_r;
  logic [OUT_WIDTH-1:0] comb1_s, comb2_s, comb3_s;
  logic [CW-1:0]        cnt_r;
  logic                 dec_s;

  generate
    if (IN_WIDTH == 1) begin : g_unsigned_in
      assign x_s = {{(OUT_WIDTH-1){1'b0}}, in};
    end else begin : g_signed_in
      assign x_s = {{(OUT_WIDTH-IN_WIDTH){in[IN_WIDTH-1]}}, in};
    end
  endgenerate

  // Integrator chain includes the current sample so the decimated value covers it
  always_comb begin
    int1_s  = int1_r + x_s;
    int2_s  = int2_r + int1_s;
    int3_s  = int3_r + int2_s;
    comb1_s = int3_s  - dly1_r;
    comb2_s = comb1_s - dly2_r;
    comb3_s = comb2_s - dly3_r;
    dec_s   = en && (cnt_r == CW'(OSR-1));
  end

  // Integrators, decimation counter and comb delays; all frozen while en=0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      int1_r <= '0;
      int2_r <= '0;
      int3_r <= '0;
      dly1_r <= '0;
      dly2_r <= '0;
      dly3_r <= '0;
      cnt_r  <= '0;
    end else if (en) begin
      int1_r <= int1_s;
      int2_r <= int2_s;
      int3_r <= int3_s;
      cnt_r  <= cnt_r + CW'(1);
      if (dec_s) begin
        dly1_r <= int3_s;
        dly2_r <= comb1_s;
        dly3_r <= comb2_s;
      end
    end
  end

  // Output register: a new sample always wins, otherwise a transfer empties it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (dec_s) begin
      out       <= comb3_s;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SINC3_DECIM_OVERRUN_EN
  // Sticky flag: set when an unaccepted sample is overwritten
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (dec_s && out_valid && !out_ready) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sinc3_decimator.sv
// Scoreboard bench for sinc3_decimator: unsigned (IN_WIDTH=1, OSR=32) and
// signed (IN_WIDTH=8, OSR=16) instances checked against a convolution model.
`timescale 1ns/1ps
module tb_sinc3_decimator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   in_mode = 0;     // 0 zero, 1 DC, 2 random, 3 most negative
  int   ready_mode = 0;  // 0 always ready, 1 never, 2 random
  int   en_mode = 0;     // 0 always, 1 every 4th clk, 2 random, 3 off
  int   cyc_n = 0;

  initial forever #5 clk = ~clk;

  genvar G;
  generate
    for (G = 0; G < 2; G++) begin : g_inst
      localparam int IW = (G == 0) ? 1 : 8;
      localparam int R  = (G == 0) ? 32 : 16;
      localparam int OW = 3*$clog2(R) + IW;

      logic [IW-1:0] in_g = '0;
      logic          ready_g = 1'b0;
      logic [OW-1:0] out_g;
      logic          valid_g;
`ifdef SINC3_DECIM_OVERRUN_EN
      logic          ovr_g;
`endif
      longint h [3*R];
      longint hist [$];
      longint expq [$];
      bit     fresh = 1'b1;
      bit     exp_ovr = 1'b0;
      int     cnt = 0;
      bit     rst_d = 1'b1;
      bit     en_d = 1'b0;
      longint x_d = 0;

      sinc3_decimator #(.IN_WIDTH(IW), .OSR(R)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .in(in_g),
        .out(out_g),
        .out_valid(valid_g),
        .out_ready(ready_g)
`ifdef SINC3_DECIM_OVERRUN_EN
        ,
        .overrun(ovr_g)
`endif
      );

      // Impulse response of three cascaded R-tap boxcars
      initial begin
        longint h2 [2*R];
        for (int n = 0; n < 2*R; n++) h2[n] = 0;
        for (int n = 0; n < 2*R-1; n++)
          for (int j = 0; j < R; j++)
            if (n-j >= 0 && n-j < R) h2[n] += 1;
        for (int n = 0; n < 3*R; n++) h[n] = 0;
        for (int n = 0; n < 3*R-2; n++)
          for (int j = 0; j < R; j++)
            if (n-j >= 0 && n-j <= 2*R-2) h[n] += h2[n-j];
      end

      // Reference model and per-instance stimulus
      initial begin
        longint y;
        longint v;
        forever begin
          @(posedge clk);
          #1;
          if (rst_d) begin
            hist.delete();
            expq.delete();
            cnt = 0;
            fresh = 1'b1;
            exp_ovr = 1'b0;
          end else if (en_d) begin
            hist.push_front(x_d);
            if (hist.size() > 3*R) void'(hist.pop_back());
            cnt++;
            if (cnt == R) begin
              cnt = 0;
              y = 0;
              for (int m = 0; m < hist.size(); m++) y += h[m] * hist[m];
              if (expq.size() > 0) begin
                void'(expq.pop_back());
                exp_ovr = 1'b1;
              end
              expq.push_back(y);
              fresh = 1'b0;
            end
          end
          #2;
          case (in_mode)
            1: v = (IW == 1) ? 64'sd1 : -64'sd64;
            2: v = longint'($urandom_range(0, (1 << IW) - 1)) - ((IW == 1) ? 0 : (1 << (IW-1)));
            3: v = (IW == 1) ? 64'sd1 : -(longint'(1) << (IW-1));
            default: v = 0;
          endcase
          in_g = v[IW-1:0];
          case (ready_mode)
            0: ready_g = 1'b1;
            1: ready_g = 1'b0;
            default: ready_g = 1'($urandom_range(0, 1));
          endcase
          rst_d = !rst_n;
          en_d  = en;
          x_d   = v;
        end
      end

      // Monitor: compares held output every cycle, pops on transfer
      initial begin
        longint t;
        logic [OW-1:0] e;
        forever begin
          @(negedge clk);
          tests++;
          if (valid_g !== (expq.size() > 0)) begin
            fails++;
            $display("FAIL inst%0d out_valid: got %0b want %0b at %0t", G, valid_g, (expq.size() > 0), $time);
          end
          if (expq.size() > 0) begin
            t = expq[0];
            e = t[OW-1:0];
            tests++;
            if (out_g !== e) begin
              fails++;
              $display("FAIL inst%0d out: got %0d want %0d at %0t", G, out_g, e, $time);
            end
            if (ready_g) void'(expq.pop_front());
          end else if (fresh) begin
            tests++;
            if (out_g !== '0) begin
              fails++;
              $display("FAIL inst%0d out_reset: got %0d want 0 at %0t", G, out_g, $time);
            end
          end
`ifdef SINC3_DECIM_OVERRUN_EN
          tests++;
          if (ovr_g !== exp_ovr) begin
            fails++;
            $display("FAIL inst%0d overrun: got %0b want %0b at %0t", G, ovr_g, exp_ovr, $time);
          end
`endif
        end
      end
    end
  endgenerate

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      cyc_n++;
      case (en_mode)
        0: en = 1'b1;
        1: en = (cyc_n % 4 == 0);
        2: en = 1'($urandom_range(0, 1));
        default: en = 1'b0;
      endcase
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    // reset then idle zero input
    cyc(3);
    rst_n = 1'b1;
    cyc(4*32 + 4);
    // DC full scale
    in_mode = 1;
    cyc(6*32 + 4);
    // backpressure for 10 decimation periods
    ready_mode = 1;
    cyc(10*32);
    ready_mode = 0;
    cyc(40);
    // en throttled to every 4th clk
    en_mode = 1;
    cyc(5*128 + 8);
    // randomized traffic
    in_mode = 2;
    en_mode = 2;
    ready_mode = 2;
    cyc(3000);
    // reset mid-operation with counter at 17 and a held sample
    rst_n = 1'b0;
    en_mode = 0;
    in_mode = 1;
    ready_mode = 1;
    cyc(1);
    rst_n = 1'b1;
    cyc(49);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    ready_mode = 0;
    cyc(3*32 + 4);
    // most-negative full scale
    in_mode = 3;
    cyc(6*32);
    in_mode = 2;
    ready_mode = 2;
    en_mode = 2;
    cyc(1500);
    ready_mode = 0;
    en_mode = 3;
    cyc(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sinc3_decimator.md
Name: sinc3_decimator

Overview:
- Receive-side counterpart of the sigma-delta modulator: a third-order CIC (sinc3) filter that turns a 1-bit or multi-bit sigma-delta stream back into decimated PCM words.
- Output is presented through a valid/ready handshake, so downstream logic (FIFO, DSP chain) can stall it.
- Sits directly after the modulator in loopback benches, and after the modulator/ADC front end in hardware.

Parameters:
- IN_WIDTH, 1, sigma-delta word width. 1 = unsigned bit (0/1); >1 = signed two's complement.
- OSR, 32, decimation ratio; power of two, 4..1024.
- OUT_WIDTH, 3*$clog2(OSR)+IN_WIDTH, output width (localparam, not overridable).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  input sample strobe; `in` is consumed only on cycles with en=1
- in  in  IN_WIDTH  sigma-delta sample
- out  out  OUT_WIDTH  decimated sample; unsigned when IN_WIDTH=1, signed otherwise
- out_valid  out  1  out holds an unconsumed sample
- out_ready  in  1  downstream accepts out when out_valid=1
- overrun  out  1  sticky; present only with SINC3_DECIM_OVERRUN_EN

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all integrators, comb delay registers, the decimation counter, out, out_valid and overrun to 0. Reset mid-operation discards any held sample.
- Reset wins over every other event in the same cycle.
- Integrators:
  - Three cascaded accumulators, each OUT_WIDTH wide.
  - Wrap-around modular arithmetic, never saturate; the comb differences remain correct under wrap.
  - Update only on en=1; input is zero- or sign-extended to OUT_WIDTH.
- Decimation counter:
  - 0..OSR-1, advances on en=1.
  - When it wraps (the OSR-th accepted sample), the third integrator value, including that sample, is latched into the comb stage.
- Comb: three cascaded differentiators with differential delay 1, evaluated once per decimation event. Comb delay registers update only on decimation events.
- Output register:
  - Loaded with the comb result 1 clk after the decimation event; out_valid=1 on that same edge.
  - Latency: the en cycle of the OSR-th sample to out_valid is exactly 1 clk.
- Handshake:
  - Transfer occurs on any edge with out_valid=1 and out_ready=1.
  - out_valid drops after the transfer unless a new sample loads on the same edge; in that case out_valid stays 1 with the new value.
  - out is stable while out_valid=1 and out_ready=0, except in the overrun case below.
  - out_ready is ignored when out_valid=0.
- Overrun: a new sample arriving while out_valid=1 and out_ready=0 overwrites out, and out_valid stays 1.
- Settling:
  - Output k (k≥1) covers inputs 1..k*OSR.
  - For a constant input x from reset, outputs k≥3 equal x*OSR^3 exactly; outputs 1 and 2 are transient.
- Full scale:
  - IN_WIDTH=1, all ones: OSR^3, which fits OUT_WIDTH unsigned.
  - Signed input: range is ±2^(IN_WIDTH-1)*OSR^3 and fits OUT_WIDTH signed, except the all-most-negative input, which maps to -2^(OUT_WIDTH-1) exactly.
- en=0 freezes all filter state; the handshake keeps operating.

Optional Feature:
- Macro SINC3_DECIM_OVERRUN_EN.
- Defined:
  - Port `overrun` exists.
  - It sets to 1 on the edge where a new sample overwrites an unaccepted one (out_valid=1, out_ready=0, new sample loading).
  - It stays set until reset; the data behaviour is unchanged (overwrite).
- Undefined: no `overrun` port and no logic; overwrite occurs silently.

Test Plan:
- Reset/idle: rst_n=0 for 3 clk, en=1, in=0 → out=0, out_valid=0 throughout reset. After reset, out=0 is emitted every 32 en-cycles (OSR=32, IN_WIDTH=1).
- DC full scale: IN_WIDTH=1, OSR=32, in=1 constant, out_ready=1 → outputs 1,2 transient; outputs ≥3 equal 32768. out_valid pulses 1 clk, exactly 1 clk after every 32nd en-cycle.
- Signed DC: IN_WIDTH=8, OSR=16, in=-64 → outputs ≥3 equal -262144 (-64*4096), OUT_WIDTH=20.
- Backpressure: out_ready=0 for 10 decimation periods, then 1 → out holds the first sample until the next decimation event, then holds the latest sample. out_valid stays 1 until the first edge with out_ready=1. overrun=1 after the 2nd event (macro on); no overrun port (macro off).
- en throttling: en=1 every 4th clk, in=1 → same output values as the DC test. Output spacing is 128 clk; state is frozen on en=0 cycles.
- Reset mid-operation: rst_n=0 for 1 clk at counter=17 with out_valid=1 → out=0, out_valid=0, overrun=0. The next output appears 1 clk after the 32nd post-reset en-cycle and is transient again.
